// File: rtl/lif_pkg.sv
// lif_pkg: state encoding, index/spike widths and neuron constants shared by lif_layer_ctrl and lif_dp
package lif_pkg;
    localparam int IDX_W = 6;
    localparam int SPK_W = 30;
    localparam int V_TH = 64;
    localparam int DECAY_SH = 3;
    typedef enum logic [2:0] {IDLE, INIT, ACC, WRITE, DONE} state_t;
endpackage

// File: rtl/lif_idx_cnt.sv
// lif_idx_cnt: clearable index counter that saturates at a terminal count and flags it
module lif_idx_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         last
);
    assign last = cnt == term;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc && !last) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/lif_layer_ctrl.sv
// lif_layer_ctrl: per-timestep sequencer for one lif_dp; LIF_CTRL_ZERO_SKIP_EN skips ACC for an all-zero input vector
module lif_layer_ctrl
    import lif_pkg::*;
#(
    parameter int N_OUT = 30,
    parameter int N_IN  = 30,
    parameter int IDX_W = lif_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clr_req,
    input  logic [SPK_W-1:0] spikes_in,
    input  logic             dp_fired,
    output logic [SPK_W-1:0] dp_spikes_bits,
    output logic [IDX_W-1:0] dp_outi,
    output logic [IDX_W-1:0] dp_ini,
    output logic             dp_clr_all,
    output logic             dp_acc_init,
    output logic             dp_acc_step,
    output logic             dp_wr1,
    output logic             dp_wr0,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] fire_cnt
);
    state_t st, nxt;
    logic [IDX_W-1:0] run_cnt;
    logic go, skip, ini_last, outi_last;
    assign go = st == IDLE && start;
`ifdef LIF_CTRL_ZERO_SKIP_EN
    assign skip = dp_spikes_bits == '0;
`else
    assign skip = 1'b0;
`endif
    lif_idx_cnt #(.W(IDX_W)) u_ini (
        .clk(clk), .rst(rst), .clr(st != ACC), .inc(st == ACC),
        .term(IDX_W'(N_IN - 1)), .cnt(dp_ini), .last(ini_last)
    );
    lif_idx_cnt #(.W(IDX_W)) u_outi (
        .clk(clk), .rst(rst), .clr(go), .inc(st == WRITE),
        .term(IDX_W'(N_OUT - 1)), .cnt(dp_outi), .last(outi_last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            dp_spikes_bits <= '0;
            run_cnt <= '0;
            fire_cnt <= '0;
        end else begin
            st <= nxt;
            if (go) dp_spikes_bits <= spikes_in;
            run_cnt <= go ? '0 : run_cnt + IDX_W'(st == WRITE && dp_fired);
            // loaded on the final WRITE so the count is already visible during DONE
            if (st == WRITE && outi_last) fire_cnt <= run_cnt + IDX_W'(dp_fired);
        end
    end
    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = start ? INIT : IDLE;
            INIT:    nxt = skip ? WRITE : ACC;
            ACC:     nxt = ini_last ? WRITE : ACC;
            WRITE:   nxt = outi_last ? DONE : INIT;
            default: nxt = IDLE;
        endcase
    end
    assign dp_clr_all  = st == IDLE && clr_req;
    assign dp_acc_init = st == INIT;
    assign dp_acc_step = st == ACC;
    assign dp_wr1      = st == WRITE && dp_fired;
    assign dp_wr0      = st == WRITE && !dp_fired;
    assign busy        = st != IDLE;
    assign done        = st == DONE;
endmodule

// File: tb/tb_lif_layer_ctrl.sv
// tb_lif_layer_ctrl: randomized run-level checks of lif_layer_ctrl against a schedule model
module tb_lif_layer_ctrl;
    localparam int N_OUT = 30;
    localparam int N_IN = 30;
`ifdef LIF_CTRL_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    logic clk = 0, rst = 1, start = 0, clr_req = 0, dp_fired;
    logic [29:0] spikes_in = '0, dp_spikes_bits;
    logic [5:0] dp_outi, dp_ini, fire_cnt;
    logic dp_clr_all, dp_acc_init, dp_acc_step, dp_wr1, dp_wr0, busy, done;
    logic [63:0] mask = '0;
    int checks = 0, errors = 0;
    bit armed = 0;
    int c_init = 0, c_acc = 0, c_wr1 = 0, c_wr0 = 0, c_done = 0, c_busy = 0;
    bit m_run = 0;
    int m_k = 0, m_cnt = 0, m_fc = 0;
    logic [29:0] m_spk = '0;

    lif_layer_ctrl #(.N_OUT(N_OUT), .N_IN(N_IN), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .clr_req(clr_req), .spikes_in(spikes_in),
        .dp_fired(dp_fired), .dp_spikes_bits(dp_spikes_bits), .dp_outi(dp_outi), .dp_ini(dp_ini),
        .dp_clr_all(dp_clr_all), .dp_acc_init(dp_acc_init), .dp_acc_step(dp_acc_step),
        .dp_wr1(dp_wr1), .dp_wr0(dp_wr0), .busy(busy), .done(done), .fire_cnt(fire_cnt)
    );
    assign dp_fired = mask[dp_outi];
    always #5 clk = ~clk;

    function automatic int per_of(logic [29:0] s);
        return (SKIP && s == 0) ? 2 : N_IN + 2;
    endfunction
    function automatic int tot_of(logic [29:0] s);
        return 1 + N_OUT * per_of(s);
    endfunction
    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Model: a run is a cycle offset k; neuron and phase follow from division by the per-neuron period
    always @(posedge clk) begin : model
        int j, per, inc;
        if (rst) begin
            m_run <= 0; m_k <= 0; m_spk <= '0; m_fc <= 0;
        end else if (!m_run) begin
            if (start) begin m_run <= 1; m_k <= 1; m_spk <= spikes_in; m_cnt <= 0; end
        end else if (m_k == tot_of(m_spk)) begin
            m_run <= 0;
        end else begin
            per = per_of(m_spk);
            j = m_k - 1;
            inc = (j % per == per - 1 && mask[j / per]) ? 1 : 0;
            m_cnt <= m_cnt + inc;
            m_k <= m_k + 1;
            if (m_k + 1 == tot_of(m_spk)) m_fc <= m_cnt + inc;
        end
    end

    always @(negedge clk) begin : compare
        int j, per, n, p;
        logic e_init, e_acc, e_wr, e_done;
        c_init += int'(dp_acc_init); c_acc += int'(dp_acc_step); c_wr1 += int'(dp_wr1);
        c_wr0 += int'(dp_wr0); c_done += int'(done); c_busy += int'(busy);
        if (armed) begin
            {e_init, e_acc, e_wr, e_done} = '0;
            n = 0; p = 0;
            if (m_run) begin
                if (m_k == tot_of(m_spk)) e_done = 1;
                else begin
                    per = per_of(m_spk); j = m_k - 1; n = j / per; p = j % per;
                    e_init = p == 0; e_wr = p == per - 1; e_acc = !e_init && !e_wr;
                end
            end
            chk("strobes", {57'b0, dp_clr_all, dp_acc_init, dp_acc_step, dp_wr1, dp_wr0, busy, done},
                {57'b0, !m_run && clr_req, e_init, e_acc, e_wr && mask[n], e_wr && !mask[n], m_run, e_done});
            chk("spikes_bits", 64'(dp_spikes_bits), 64'(m_spk));
            chk("fire_cnt", 64'(fire_cnt), 64'(m_fc));
            if (m_run && !e_done) chk("outi", 64'(dp_outi), 64'(n));
            if (e_init || e_acc) chk("ini", 64'(dp_ini), 64'(e_acc ? p - 1 : 0));
        end
    end

    task automatic zero_chk(string name);
        chk(name, {dp_spikes_bits, dp_outi, dp_ini, fire_cnt, dp_clr_all, dp_acc_init, dp_acc_step,
                   dp_wr1, dp_wr0, busy, done}, 64'd0);
    endtask

    task automatic run(input logic [29:0] spk, input logic [63:0] msk, input bit with_clr,
                       input int rst_at, output int lat);
        int w;
        mask = msk; spikes_in = spk; start = 1; clr_req = with_clr;
        tick();
        clr_req = 0;
        for (w = 0; w < 4 && !busy; w++) tick();
        start = 0;
        lat = 1;
        if (!busy) begin chk("accept", 0, 1); return; end
        while (!done && lat < 3000) begin
            if (lat == rst_at) begin
                rst = 1; tick(); zero_chk("rst_mid_run"); rst = 0;
                return;
            end
            start = lat == 100;
            clr_req = lat == 200;
            if (lat % 37 == 0) spikes_in = 30'($urandom);
            tick();
            lat++;
        end
        start = 0; clr_req = 0;
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int lat, b0, d0, i0, a0, w10, w00;
        logic [29:0] s;
        logic [63:0] m;
        repeat (3) tick();
        armed = 1;
        zero_chk("reset_state");
        rst = 0;
        tick();
        b0 = c_busy; d0 = c_done; i0 = c_init; a0 = c_acc; w10 = c_wr1; w00 = c_wr0;
        run(30'h3FFFFFFF, 64'h2000_0081, 0, -1, lat);
        chk("lat_full", 64'(lat), 961);
        chk("busy_cycles", 64'(c_busy - b0), 961);
        chk("done_count", 64'(c_done - d0), 1);
        chk("init_count", 64'(c_init - i0), 30);
        chk("acc_count", 64'(c_acc - a0), 900);
        chk("wr1_count", 64'(c_wr1 - w10), 3);
        chk("wr0_count", 64'(c_wr0 - w00), 27);
        chk("fire_cnt_lit", 64'(fire_cnt), 3);
        tick(); tick();
        run(30'($urandom), 64'($urandom) & 64'h3FFFFFFF, 0, 500, lat);
        tick();
        m = 64'($urandom) & 64'h3FFFFFFF;
        s = 30'($urandom) | 30'h1;
        run(s, m, 1, -1, lat);
        chk("lat_after_rst", 64'(lat), 961);
        chk("fire_cnt_after_rst", 64'(fire_cnt), 64'($countones(m)));
        tick();
        a0 = c_acc;
        run(30'h0, 64'h3FFFFFFF, 0, -1, lat);
        chk("lat_zero_in", 64'(lat), SKIP ? 61 : 961);
        chk("acc_zero_in", 64'(c_acc - a0), SKIP ? 0 : 900);
        chk("fire_cnt_zero_in", 64'(fire_cnt), 30);
        for (int r = 0; r < 6; r++) begin
            m = 64'($urandom) & 64'h3FFFFFFF;
            s = ($urandom_range(0, 2) == 0) ? 30'h0 : 30'($urandom);
            clr_req = 1'($urandom);
            run(s, m, 1'($urandom), -1, lat);
            chk("lat_rand", 64'(lat), 64'(tot_of(s)));
            chk("fire_cnt_rand", 64'(fire_cnt), 64'($countones(m)));
        end
        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
